led_matrix_scan_ctrl: RTL and testbench
=======================================

Name: led_matrix_scan_ctrl

Overview:
- Row-scan driver for the 8x8 red/green bicolour LED matrix of the checkerboard display.
- Reads the 64-cell board state RAM (2 bits/cell) one row ahead, drives one row at a time plus red/green column lines.
- Applies whole-screen blink and single-point blink overlays.
- Sits between the board state RAM and the LED matrix pins.

Parameters:
- RAM_RD_LATENCY, 1, clocks from ram_rd_addr change to valid ram_data (0 = combinational RAM).
- BLANK_CYCLES, 2, clocks of column blanking after each row change (used only with the optional feature).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- scan_tick  in  1  one-clk pulse; advance to next row.
- en  in  1  enable; low = matrix dark, scanning frozen.
- flicker_tick  in  1  one-clk pulse; toggles blink phase.
- screen_flicker_en  in  1  blink entire screen.
- point_flicker_en  in  1  blink one cell.
- point_flicker_pos  in  6  cell {row[2:0], col[2:0]}.
- point_flicker_color  in  1  0 = red (SIDE_RED), 1 = green (SIDE_GREEN).
- ram_rd_addr  out  6  state RAM read address {row, col} = row*8+col.
- ram_data  in  2  cell state {red, green}: 00 empty, 10 red, 01 green, 11 both.
- led_row  out  8  row select, one-hot active-low; bit r = row r.
- led_col_red  out  8  red column drive, active-high; bit c = column c.
- led_col_green  out  8  green column drive, active-high; bit c = column c.

Behaviour:
- Reset: led_row = 8'hFF, led_col_red = 0, led_col_green = 0, ram_rd_addr = 0, disp_row = 7, phase = 0, both buffers cleared, prefetch of row 0 starts on the first clk after reset release.
- Prefetch: after every row switch (and after reset), fetch the next row's 8 cells.
  - Issue col 0..7 on consecutive clks.
  - Capture ram_data RAM_RD_LATENCY clks after each address into prefetch buffer bit [col].
  - Complete within 8+RAM_RD_LATENCY clks, then idle.
  - scan_tick spacing must be at least 10 clks. A tick arriving mid-fetch is still honoured; the partially filled buffer is shown.
- scan_tick with en=1:
  - disp_row <= disp_row+1 (wraps 7 -> 0).
  - Display buffer <= prefetch buffer.
  - Prefetch for (new disp_row+1) mod 8 restarts.
- Output registers update every clk; one clk latency from buffer/overlay change to pins.
  - led_row = ~(1 << disp_row).
  - Columns come from the display buffer after overlays.
- Blink phase: toggles on each flicker_tick regardless of en.
- Overlay priority, highest first:
  - en=0: led_row = FF, cols = 0, disp_row and prefetch frozen, scan_tick ignored.
  - screen_flicker_en=1 and phase=1: cols = 0, rows still scanned.
  - point_flicker_en=1 and point_flicker_pos[5:3] = disp_row, for column point_flicker_pos[2:0] only:
    - phase=0: red=1,green=0 if colour=0; red=0,green=1 if colour=1.
    - phase=1: both 0.
    - Overrides RAM content for that cell only; other cells unchanged.
  - Otherwise: RAM content.
- Overlay inputs are sampled every clk (no latching); changes take effect next clk.
- RAM writes appear on the display no later than the second scan of the written row after the write.
- Reset asserted mid-operation: immediate return to reset values, no glitch beyond the async clear.

Optional Feature:
- SCAN_BLANKING_EN:
  - Defined: for BLANK_CYCLES clks after each row switch, cols forced to 0 (led_row already shows the new row), suppressing ghosting.
  - Undefined: columns switch in the same clk as the row; no blanking.

Test Plan:
- Reset, en=1, RAM row 0 = {R,_,_,_,_,_,_,_}, one scan_tick -> next clk led_row=8'hFE, led_col_red=8'h01, led_col_green=8'h00.
- Board with row 7 = {_,G,_,_,_,R,G,R}, 8 ticks -> at row 7: led_row=8'h7F, red=8'hA0, green=8'h42; the next tick wraps to row 0.
- Empty board, point_flicker_en=1, pos={2,2}, colour=0 -> while row 2 is active: phase 0 gives red=8'h04, green=0; after a flicker_tick (phase 1) gives red=0; other rows always 0.
- pos={0,7}, colour=1, RAM cell (0,7)=R -> phase 0: row 0 green=8'h80, red=8'h00; phase 1: both 0.
- screen_flicker_en=1, full board -> phase 1: all cols 0 while led_row keeps cycling; phase 0: normal image.
- en=0 mid-scan -> led_row=8'hFF, cols 0, scan_ticks ignored; en=1 -> resumes from the frozen row. Reset mid-scan -> reset values immediately.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan driver for the 8x8 red/green LED matrix: prefetches the next row from the board RAM
// and applies screen/point blink overlays. Optional SCAN_BLANKING_EN blanks columns after row changes.
module led_matrix_scan_ctrl #(
    parameter int unsigned RAM_RD_LATENCY = 1,
    parameter int unsigned BLANK_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_tick,
    input  logic       en,
    input  logic       flicker_tick,
    input  logic       screen_flicker_en,
    input  logic       point_flicker_en,
    input  logic [5:0] point_flicker_pos,
    input  logic       point_flicker_color,
    output logic [5:0] ram_rd_addr,
    input  logic [1:0] ram_data,
    output logic [7:0] led_row,
    output logic [7:0] led_col_red,
    output logic [7:0] led_col_green
);

    localparam int unsigned PipeDepth = (RAM_RD_LATENCY == 0) ? 1 : RAM_RD_LATENCY;

    logic [2:0] disp_row_q, fetch_row_q, issue_col_q;
    logic       issue_active_q, phase_q;
    logic [7:0] pf_red_q, pf_green_q, dsp_red_q, dsp_green_q;

    logic [PipeDepth-1:0] pipe_vld_q;
    logic [2:0]           pipe_col_q [PipeDepth];

    logic       row_switch, cap_vld, blank;
    logic [2:0] cap_col;
    logic [7:0] row_d, red_d, green_d;

    assign row_switch  = scan_tick & en;
    assign ram_rd_addr = {fetch_row_q, issue_col_q};

    // With a combinational RAM the current address is captured directly; otherwise the
    // pipeline tags each issued column until its data arrives.
    assign cap_vld = (RAM_RD_LATENCY == 0) ? (issue_active_q & en) : pipe_vld_q[PipeDepth-1];
    assign cap_col = (RAM_RD_LATENCY == 0) ? issue_col_q : pipe_col_q[PipeDepth-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_row_q     <= 3'd7;
            fetch_row_q    <= 3'd0;
            issue_col_q    <= 3'd0;
            issue_active_q <= 1'b1;
            phase_q        <= 1'b0;
            pf_red_q       <= '0;
            pf_green_q     <= '0;
            dsp_red_q      <= '0;
            dsp_green_q    <= '0;
            pipe_vld_q     <= '0;
            for (int i = 0; i < PipeDepth; i++) pipe_col_q[i] <= 3'd0;
        end else begin
            if (flicker_tick) phase_q <= ~phase_q;

            for (int i = PipeDepth - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_col_q[i] <= pipe_col_q[i-1];
            end
            pipe_vld_q[0] <= issue_active_q & en;
            pipe_col_q[0] <= issue_col_q;

            if (row_switch) begin
                disp_row_q     <= disp_row_q + 3'd1;
                fetch_row_q    <= disp_row_q + 3'd2;
                issue_col_q    <= 3'd0;
                issue_active_q <= 1'b1;
                dsp_red_q      <= pf_red_q;
                dsp_green_q    <= pf_green_q;
                pf_red_q       <= '0;
                pf_green_q     <= '0;
                // Reads still in flight belong to the old row.
                pipe_vld_q     <= '0;
            end else begin
                if (issue_active_q && en) begin
                    if (issue_col_q == 3'd7) issue_active_q <= 1'b0;
                    else                     issue_col_q    <= issue_col_q + 3'd1;
                end
                if (cap_vld) begin
                    pf_red_q[cap_col]   <= ram_data[1];
                    pf_green_q[cap_col] <= ram_data[0];
                end
            end
        end
    end

`ifdef SCAN_BLANKING_EN
    logic [7:0] blank_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt_q <= '0;
        end else if (row_switch) begin
            blank_cnt_q <= 8'(BLANK_CYCLES);
        end else if (blank_cnt_q != 8'd0) begin
            blank_cnt_q <= blank_cnt_q - 8'd1;
        end
    end

    assign blank = (blank_cnt_q != 8'd0);
`else
    logic unused_blank_cycles;
    assign unused_blank_cycles = ^BLANK_CYCLES;
    assign blank = 1'b0;
`endif

    always_comb begin
        row_d   = ~(8'd1 << disp_row_q);
        red_d   = dsp_red_q;
        green_d = dsp_green_q;
        if (point_flicker_en && (point_flicker_pos[5:3] == disp_row_q)) begin
            red_d[point_flicker_pos[2:0]]   = ~phase_q & ~point_flicker_color;
            green_d[point_flicker_pos[2:0]] = ~phase_q & point_flicker_color;
        end
        if ((screen_flicker_en && phase_q) || blank) begin
            red_d   = '0;
            green_d = '0;
        end
        if (!en) begin
            row_d   = 8'hFF;
            red_d   = '0;
            green_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_row       <= 8'hFF;
            led_col_red   <= '0;
            led_col_green <= '0;
        end else begin
            led_row       <= row_d;
            led_col_red   <= red_d;
            led_col_green <= green_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed self-checking bench for led_matrix_scan_ctrl with a 1-clock-latency board RAM model.
module tb_led_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_tick = 1'b0;
    logic       en = 1'b0;
    logic       flicker_tick = 1'b0;
    logic       screen_flicker_en = 1'b0;
    logic       point_flicker_en = 1'b0;
    logic [5:0] point_flicker_pos = 6'd0;
    logic       point_flicker_color = 1'b0;
    logic [5:0] ram_rd_addr;
    logic [1:0] ram_data = 2'b00;
    logic [7:0] led_row, led_col_red, led_col_green;

    logic [1:0] mem [64];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[ram_rd_addr];

    led_matrix_scan_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .scan_tick           (scan_tick),
        .en                  (en),
        .flicker_tick        (flicker_tick),
        .screen_flicker_en   (screen_flicker_en),
        .point_flicker_en    (point_flicker_en),
        .point_flicker_pos   (point_flicker_pos),
        .point_flicker_color (point_flicker_color),
        .ram_rd_addr         (ram_rd_addr),
        .ram_data            (ram_data),
        .led_row             (led_row),
        .led_col_red         (led_col_red),
        .led_col_green       (led_col_green)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [7:0] row, input logic [7:0] red,
                              input logic [7:0] green);
        check({tag, ".row"}, led_row, row);
        check({tag, ".red"}, led_col_red, red);
        check({tag, ".green"}, led_col_green, green);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-clock tick, then enough idle clocks for the next-row prefetch to finish.
    task automatic tick();
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        step(11);
    endtask

    task automatic flick();
        flicker_tick = 1'b1;
        @(negedge clk);
        flicker_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;
        mem[0]  = 2'b10;
        mem[57] = 2'b01;
        mem[61] = 2'b10;
        mem[62] = 2'b01;
        mem[63] = 2'b10;

        en = 1'b1;
        step(2);
        check_pins("reset", 8'hFF, 8'h00, 8'h00);
        check("reset.addr", {2'b00, ram_rd_addr}, 8'h00);
        rst_n = 1'b1;
        step(12);
        check_pins("idle_row7", 8'h7F, 8'h00, 8'h00);

        tick();
        check_pins("row0", 8'hFE, 8'h01, 8'h00);
        check("row0.addr", {2'b00, ram_rd_addr}, 8'h0F);
        for (int i = 0; i < 6; i++) tick();
        check_pins("row6", 8'hBF, 8'h00, 8'h00);
        tick();
        check_pins("row7", 8'h7F, 8'hA0, 8'h42);
        check("row7.addr", {2'b00, ram_rd_addr}, 8'h07);
        tick();
        check_pins("wrap_row0", 8'hFE, 8'h01, 8'h00);

        // Cell (0,7) becomes red; row 0 is refetched while row 7 is shown.
        mem[0] = 2'b00;
        mem[7] = 2'b10;

        point_flicker_en    = 1'b1;
        point_flicker_pos   = {3'd2, 3'd2};
        point_flicker_color = 1'b0;
        tick();
        check_pins("pt22_row1", 8'hFD, 8'h00, 8'h00);
        tick();
        check_pins("pt22_ph0", 8'hFB, 8'h04, 8'h00);
        flick();
        check_pins("pt22_ph1", 8'hFB, 8'h00, 8'h00);
        flick();
        check_pins("pt22_ph0b", 8'hFB, 8'h04, 8'h00);
        tick();
        check_pins("pt22_row3", 8'hF7, 8'h00, 8'h00);

        point_flicker_pos   = {3'd0, 3'd7};
        point_flicker_color = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_pins("pt07_row7", 8'h7F, 8'hA0, 8'h42);
        tick();
        check_pins("pt07_ph0", 8'hFE, 8'h00, 8'h80);
        flick();
        check_pins("pt07_ph1", 8'hFE, 8'h00, 8'h00);
        flick();
        point_flicker_en = 1'b0;
        step(1);
        check_pins("row0_ram", 8'hFE, 8'h80, 8'h00);

        for (int i = 0; i < 64; i++) mem[i] = 2'b11;
        screen_flicker_en = 1'b1;
        tick();
        check_pins("scr_row1_old", 8'hFD, 8'h00, 8'h00);
        tick();
        check_pins("scr_ph0", 8'hFB, 8'hFF, 8'hFF);
        flick();
        check_pins("scr_ph1", 8'hFB, 8'h00, 8'h00);
        tick();
        check_pins("scr_ph1_row3", 8'hF7, 8'h00, 8'h00);
        flick();
        check_pins("scr_ph0_row3", 8'hF7, 8'hFF, 8'hFF);
        screen_flicker_en = 1'b0;

        en = 1'b0;
        step(1);
        check_pins("en0", 8'hFF, 8'h00, 8'h00);
        tick();
        check_pins("en0_tick", 8'hFF, 8'h00, 8'h00);
        flick();
        flick();
        en = 1'b1;
        step(1);
        check_pins("en1_resume", 8'hF7, 8'hFF, 8'hFF);
        tick();
        check_pins("en1_row4", 8'hEF, 8'hFF, 8'hFF);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_pins("midreset", 8'hFF, 8'h00, 8'h00);
        check("midreset.addr", {2'b00, ram_rd_addr}, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
